// File: rtl/demux_pkg.sv
// Shared definitions for the demux select sequencer: channel count,
// select width, hold-counter width and the sequencer state encoding.
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_hold_cnt.sv
// Hold counter: counts 0..HOLD_CYC-1 after each start, then parks on the
// terminal value. tick_out marks the last cycle of the current hold.
module demux_hold_cnt
  import demux_pkg::*;
#(
  parameter int HOLD_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic tick_out
);

  localparam logic [HOLD_W-1:0] TERM = HOLD_W'(HOLD_CYC - 1);

  logic [HOLD_W-1:0] count;

  // Reload on start, otherwise advance until the terminal count is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (count != TERM) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign tick_out = (count == TERM);

endmodule

// File: rtl/demux_sel_sequencer.sv
// Serialises an 8-bit frame onto a 1:8 demux: each bit is driven on D with
// its channel number on S for HOLD_CYC cycles, qualified by d_strobe.
// Every output is a flop; the next-state logic only feeds the flop inputs.
module demux_sel_sequencer
  import demux_pkg::*;
#(
  parameter int HOLD_CYC  = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             D,
  output logic [SEL_W-1:0] S,
  output logic             d_strobe,
  output logic             frame_done,
  output logic             busy
);

  // First and last channel of a frame depend on the scan direction; the
  // end of a frame is detected on the last index, so S never wraps.
  localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(NUM_CH - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_SEL  = MSB_FIRST ? '0 : SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

  state_t           state, state_nxt;
  logic [7:0]       frame_reg, frame_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic             d_nxt;
  logic             strobe_nxt;
  logic             done_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             hold_start;
  logic             hold_tick;

  demux_hold_cnt #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (hold_start),
    .tick_out (hold_tick)
  );

  // Next-state and next-output logic; D/S keep their values unless reloaded
  always_comb begin
    state_nxt  = state;
    frame_nxt  = frame_reg;
    s_nxt      = S;
    d_nxt      = D;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    hold_start = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready && in_valid) begin
          frame_nxt  = data_in;
          s_nxt      = FIRST_SEL;
          d_nxt      = data_in[FIRST_SEL];
          strobe_nxt = 1'b1;
          hold_start = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        strobe_nxt = 1'b1;
        if (hold_tick) begin
          if (S == LAST_SEL) begin
            strobe_nxt = 1'b0;
            done_nxt   = 1'b1;
            state_nxt  = DONE;
          end else begin
            s_nxt      = MSB_FIRST ? (S - SEL_ONE) : (S + SEL_ONE);
            d_nxt      = frame_reg[s_nxt];
            hold_start = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State, frame and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_reg  <= '0;
      S          <= '0;
      D          <= 1'b0;
      d_strobe   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_reg  <= frame_nxt;
      S          <= s_nxt;
      D          <= d_nxt;
      d_strobe   <= strobe_nxt;
      frame_done <= done_nxt;
      busy       <= busy_nxt;
      in_ready   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: two instances (default parameters, and
// MSB_FIRST=1 with HOLD_CYC=3) against a frame-index reference model,
// directed frames from the requirements plus randomized traffic and resets.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din0, din1;
  logic       vld0, vld1;
  logic       in_ready0, in_ready1;
  logic       D0, D1;
  logic [2:0] S0, S1;
  logic       d_strobe0, d_strobe1;
  logic       frame_done0, frame_done1;
  logic       busy0, busy1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] y_acc0 = '0;
  logic [7:0] last_y0 = '0;
  int         n_str0 = 0;
  bit         exp_d0 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  demux_sel_sequencer u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (din0),
    .in_valid   (vld0),
    .in_ready   (in_ready0),
    .D          (D0),
    .S          (S0),
    .d_strobe   (d_strobe0),
    .frame_done (frame_done0),
    .busy       (busy0)
  );

  demux_sel_sequencer #(
    .HOLD_CYC  (3),
    .MSB_FIRST (1'b1)
  ) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (din1),
    .in_valid   (vld1),
    .in_ready   (in_ready1),
    .D          (D1),
    .S          (S1),
    .d_strobe   (d_strobe1),
    .frame_done (frame_done1),
    .busy       (busy1)
  );

  // Reference model: a frame is a position idx in 0..8*hold; position p < 8*hold
  // shows channel p/hold, position 8*hold is the completion cycle.
  typedef struct packed {
    logic        active;
    logic [7:0]  data;
    logic [15:0] idx;
    logic        ready;
    logic        busy;
    logic        strobe;
    logic        done;
    logic [2:0]  s;
    logic        d;
  } m_t;

  m_t m0, m1;

  function automatic m_t model_next(m_t m, logic v, logic [7:0] din, int hold, bit msb);
    m_t n;
    int idx;
    int ch;
    int sel;
    n = m;
    if (m.active) begin
      idx   = int'(m.idx) + 1;
      n.idx = 16'(idx);
      if (idx > 8 * hold) n.active = 1'b0;
    end else if (m.ready && v) begin
      n.active = 1'b1;
      n.data   = din;
      n.idx    = '0;
    end
    idx = int'(n.idx);
    if (n.active) begin
      n.ready = 1'b0;
      n.busy  = 1'b1;
      if (idx < 8 * hold) begin
        ch       = idx / hold;
        sel      = msb ? (7 - ch) : ch;
        n.s      = 3'(sel);
        n.d      = n.data[sel];
        n.strobe = 1'b1;
        n.done   = 1'b0;
      end else begin
        n.strobe = 1'b0;
        n.done   = 1'b1;
      end
    end else begin
      n.ready  = 1'b1;
      n.busy   = 1'b0;
      n.strobe = 1'b0;
      n.done   = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= model_next(m0, vld0, din0, 1, 1'b0);
      m1 <= model_next(m1, vld1, din1, 3, 1'b1);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus demux Y capture on dut0
  task automatic compare_all();
    chk("ready0",  8'(in_ready0),   8'(m0.ready));
    chk("busy0",   8'(busy0),       8'(m0.busy));
    chk("strobe0", 8'(d_strobe0),   8'(m0.strobe));
    chk("done0",   8'(frame_done0), 8'(m0.done));
    chk("S0",      8'(S0),          8'(m0.s));
    chk("D0",      8'(D0),          8'(m0.d));
    chk("ready1",  8'(in_ready1),   8'(m1.ready));
    chk("busy1",   8'(busy1),       8'(m1.busy));
    chk("strobe1", 8'(d_strobe1),   8'(m1.strobe));
    chk("done1",   8'(frame_done1), 8'(m1.done));
    chk("S1",      8'(S1),          8'(m1.s));
    chk("D1",      8'(D1),          8'(m1.d));
    if (!rst_n) begin
      y_acc0 = '0;
      n_str0 = 0;
    end else begin
      if (d_strobe0) begin
        y_acc0[S0] = D0;
        n_str0++;
      end
      if (frame_done0) begin
        chk("ycap0", y_acc0, m0.data);
        chk("ystrobes0", 8'(n_str0), 8'd8);
        last_y0 = y_acc0;
        y_acc0  = '0;
        n_str0  = 0;
      end
    end
  endtask

  // One clock: compare on the falling edge, then return just after the rising edge
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0(input string name);
    int i;
    for (i = 0; i < 40 && !in_ready0; i++) tick();
    if (!in_ready0) chk(name, 8'(in_ready0), 8'd1);
  endtask

  task automatic wait_done0(input string name);
    int i;
    for (i = 0; i < 40 && !frame_done0; i++) tick();
    chk(name, 8'(frame_done0), 8'd1);
  endtask

  initial begin
    din0 = '0; din1 = '0; vld0 = 1'b0; vld1 = 1'b0;
    @(posedge clk);
    #1;
    // Reset state
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ready", 8'(in_ready0), 8'd0);
    chk("rst_busy",  8'(busy0),     8'd0);
    chk("rst_S",     8'(S0),        8'd0);
    chk("rst_strb",  8'(d_strobe0), 8'd0);
    rst_n = 1'b1;
    chk("rel_ready_before_edge", 8'(in_ready0), 8'd0);
    tick();
    chk("rel_ready_after_edge", 8'(in_ready0), 8'd1);

    // A5 on the default instance, 81 on the MSB-first/hold-3 instance
    din0 = 8'hA5; vld0 = 1'b1;
    din1 = 8'h81; vld1 = 1'b1;
    tick();
    vld0 = 1'b0; vld1 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c <= 8) begin
        chk("a5_S", 8'(S0), 8'(c - 1));
        chk("a5_D", 8'(D0), 8'(exp_d0[c-1]));
        chk("a5_strobe", 8'(d_strobe0), 8'd1);
      end else if (c == 9) begin
        chk("a5_done", 8'(frame_done0), 8'd1);
        chk("a5_strobe_off", 8'(d_strobe0), 8'd0);
      end else if (c == 10) begin
        chk("a5_ready_back", 8'(in_ready0), 8'd1);
      end
      if (c <= 24) begin
        chk("81_S", 8'(S1), 8'(7 - (c - 1) / 3));
        chk("81_D", 8'(D1), ((c <= 3) || (c >= 22)) ? 8'd1 : 8'd0);
      end else if (c == 25) begin
        chk("81_done", 8'(frame_done1), 8'd1);
      end else begin
        chk("81_done_pulse", 8'(frame_done1), 8'd0);
        chk("81_ready_back", 8'(in_ready1), 8'd1);
      end
      tick();
    end

    // in_valid held high with data changing during SEND
    vld0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      din0 = 8'($urandom);
      tick();
    end
    vld0 = 1'b0;

    // Reset pulse in the middle of a frame at S=4
    wait_ready0("mid_rst_ready");
    din0 = 8'($urandom); vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    for (int i = 0; i < 12 && !(d_strobe0 && S0 == 3'd4); i++) tick();
    chk("mid_rst_reach_S4", 8'(S0), 8'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_S",     8'(S0),          8'd0);
    chk("mid_rst_D",     8'(D0),          8'd0);
    chk("mid_rst_busy",  8'(busy0),       8'd0);
    chk("mid_rst_strb",  8'(d_strobe0),   8'd0);
    chk("mid_rst_ready", 8'(in_ready0),   8'd0);
    chk("mid_rst_done",  8'(frame_done0), 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_ready_after", 8'(in_ready0), 8'd1);
    chk("mid_rst_no_done", 8'(frame_done0), 8'd0);

    // Back-to-back FF then 00 reconstructed through the demux capture
    wait_ready0("b2b_ready");
    din0 = 8'hFF; vld0 = 1'b1;
    tick();
    din0 = 8'h00;
    wait_done0("b2b_done_ff");
    tick();
    chk("b2b_y_ff", last_y0, 8'hFF);
    tick();
    vld0 = 1'b0;
    chk("b2b_second_started", 8'(busy0), 8'd1);
    wait_done0("b2b_done_00");
    tick();
    chk("b2b_y_00", last_y0, 8'h00);

    // Randomized traffic on both instances with occasional resets
    for (int i = 0; i < 1500; i++) begin
      vld0 = ($urandom_range(0, 2) == 0);
      vld1 = ($urandom_range(0, 2) == 0);
      din0 = 8'($urandom);
      din1 = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    vld0 = 1'b0; vld1 = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
